// File: rtl/openmips_pkg.sv
// Shared openMIPS definitions: ALU op codes, opcode/funct constants and the ID decode table.
package openmips_pkg;

    localparam int unsigned ALUOP_W = 4;

    localparam logic [ALUOP_W-1:0] ALU_NOP = 4'd0;
    localparam logic [ALUOP_W-1:0] ALU_OR  = 4'd1;
    localparam logic [ALUOP_W-1:0] ALU_AND = 4'd2;
    localparam logic [ALUOP_W-1:0] ALU_XOR = 4'd3;
    localparam logic [ALUOP_W-1:0] ALU_ADD = 4'd4;
    localparam logic [ALUOP_W-1:0] ALU_SUB = 4'd5;
    localparam logic [ALUOP_W-1:0] ALU_SLT = 4'd6;
    localparam logic [ALUOP_W-1:0] ALU_SLL = 4'd7;
    localparam logic [ALUOP_W-1:0] ALU_SRL = 4'd8;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    typedef enum logic [1:0] {S0_ZERO, S0_RS, S0_RT} src0_sel_e;
    typedef enum logic [2:0] {S1_ZIMM, S1_SIMM, S1_LUI, S1_SHAMT, S1_RT} src1_sel_e;

    typedef struct packed {
        logic [ALUOP_W-1:0] aluop;
        src0_sel_e          s0;
        src1_sel_e          s1;
        logic               use_rs;
        logic               use_rt;
        logic               dest_rd;
        logic               wr;
        logic               is_load;
        logic               illegal;
    } dec_t;

    // Control-only decode; operand values and the dest==0 write kill are applied by the stage.
    function automatic dec_t decode(input logic [5:0] op, input logic [5:0] funct);
        dec_t d;
        d.aluop   = ALU_NOP;
        d.s0      = S0_ZERO;
        d.s1      = S1_ZIMM;
        d.use_rs  = 1'b0;
        d.use_rt  = 1'b0;
        d.dest_rd = 1'b0;
        d.wr      = 1'b0;
        d.is_load = 1'b0;
        d.illegal = 1'b0;
        case (op)
            OP_ORI:   begin d.aluop = ALU_OR;  d.s0 = S0_RS; d.s1 = S1_ZIMM; d.use_rs = 1'b1; d.wr = 1'b1; end
            OP_ANDI:  begin d.aluop = ALU_AND; d.s0 = S0_RS; d.s1 = S1_ZIMM; d.use_rs = 1'b1; d.wr = 1'b1; end
            OP_XORI:  begin d.aluop = ALU_XOR; d.s0 = S0_RS; d.s1 = S1_ZIMM; d.use_rs = 1'b1; d.wr = 1'b1; end
            OP_ADDIU: begin d.aluop = ALU_ADD; d.s0 = S0_RS; d.s1 = S1_SIMM; d.use_rs = 1'b1; d.wr = 1'b1; end
            OP_LUI:   begin d.aluop = ALU_OR;  d.s0 = S0_ZERO; d.s1 = S1_LUI; d.wr = 1'b1; end
            OP_LW: begin
                d.aluop = ALU_ADD; d.s0 = S0_RS; d.s1 = S1_SIMM; d.use_rs = 1'b1;
                d.wr = 1'b1; d.is_load = 1'b1;
            end
            OP_SPECIAL: begin
                d.dest_rd = 1'b1;
                d.wr      = 1'b1;
                d.s0      = S0_RS;
                d.s1      = S1_RT;
                d.use_rs  = 1'b1;
                d.use_rt  = 1'b1;
                case (funct)
                    FN_AND:  d.aluop = ALU_AND;
                    FN_OR:   d.aluop = ALU_OR;
                    FN_XOR:  d.aluop = ALU_XOR;
                    FN_ADDU: d.aluop = ALU_ADD;
                    FN_SUBU: d.aluop = ALU_SUB;
                    FN_SLT:  d.aluop = ALU_SLT;
                    FN_SLL:  begin d.aluop = ALU_SLL; d.s0 = S0_RT; d.s1 = S1_SHAMT; d.use_rs = 1'b0; end
                    FN_SRL:  begin d.aluop = ALU_SRL; d.s0 = S0_RT; d.s1 = S1_SHAMT; d.use_rs = 1'b0; end
                    default: begin
                        d.aluop = ALU_NOP; d.wr = 1'b0; d.illegal = 1'b1;
                        d.s0 = S0_ZERO; d.s1 = S1_ZIMM; d.use_rs = 1'b0; d.use_rt = 1'b0;
                    end
                endcase
            end
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/id_fwd_mux.sv
// Resolves one source operand: $0, then EX result, then MEM result, then regfile data.
module id_fwd_mux #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5
) (
    input  logic [AW-1:0] raddr_i,
    input  logic [DW-1:0] rdata_i,
    input  logic          ex_we_i,
    input  logic [AW-1:0] ex_waddr_i,
    input  logic [DW-1:0] ex_wdata_i,
    input  logic          mem_we_i,
    input  logic [AW-1:0] mem_waddr_i,
    input  logic [DW-1:0] mem_wdata_i,
    output logic [DW-1:0] operand_c
);

    always_comb begin
        operand_c = rdata_i;
        if (raddr_i == '0) begin
            operand_c = '0;
        end else if (ex_we_i && (ex_waddr_i == raddr_i)) begin
            operand_c = ex_wdata_i;
        end else if (mem_we_i && (mem_waddr_i == raddr_i)) begin
            operand_c = mem_wdata_i;
        end
    end

endmodule

// File: rtl/id_stage.sv
// openMIPS decode stage: IF/ID register, decode, operand forwarding, load-use stall, ID/EX register.
module id_stage
    import openmips_pkg::*;
#(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5
) (
    input  logic               clk,
    input  logic               rst_,
    input  logic               if_valid,
    input  logic [DW-1:0]      if_pc,
    input  logic [31:0]        if_inst,
    input  logic               flush,
    output logic               stall_req,
    output logic               re0,
    output logic               re1,
    output logic [AW-1:0]      raddr0,
    output logic [AW-1:0]      raddr1,
    input  logic [DW-1:0]      rdata0,
    input  logic [DW-1:0]      rdata1,
    input  logic               fwd_ex_we,
    input  logic               fwd_ex_is_load,
    input  logic [AW-1:0]      fwd_ex_waddr,
    input  logic [DW-1:0]      fwd_ex_wdata,
    input  logic               fwd_mem_we,
    input  logic [AW-1:0]      fwd_mem_waddr,
    input  logic [DW-1:0]      fwd_mem_wdata,
    output logic               idex_valid,
    output logic [ALUOP_W-1:0] idex_aluop,
    output logic [DW-1:0]      idex_src0,
    output logic [DW-1:0]      idex_src1,
    output logic               idex_we,
    output logic [AW-1:0]      idex_waddr,
    output logic               idex_is_load,
    output logic               idex_illegal,
    output logic [DW-1:0]      idex_pc
);

    logic          ifid_valid_q;
    logic [DW-1:0] ifid_pc_q;
    logic [31:0]   ifid_inst_q;

    // IF/ID register: flush beats stall.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            ifid_valid_q <= 1'b0;
            ifid_pc_q    <= '0;
            ifid_inst_q  <= '0;
        end else if (flush) begin
            ifid_valid_q <= 1'b0;
        end else if (!stall_req) begin
            ifid_valid_q <= if_valid;
            ifid_pc_q    <= if_pc;
            ifid_inst_q  <= if_inst;
        end
    end

    logic [5:0]    op, funct;
    logic [AW-1:0] rs, rt, rd;
    logic [4:0]    shamt;
    logic [15:0]   imm;
    dec_t          dec;

    assign op    = ifid_inst_q[31:26];
    assign rs    = AW'(ifid_inst_q[25:21]);
    assign rt    = AW'(ifid_inst_q[20:16]);
    assign rd    = AW'(ifid_inst_q[15:11]);
    assign shamt = ifid_inst_q[10:6];
    assign imm   = ifid_inst_q[15:0];
    assign funct = ifid_inst_q[5:0];
    assign dec   = decode(op, funct);

    assign re0    = ifid_valid_q & dec.use_rs;
    assign re1    = ifid_valid_q & dec.use_rt;
    assign raddr0 = rs;
    assign raddr1 = rt;

    logic [DW-1:0] op0_c, op1_c;

    id_fwd_mux #(.DW(DW), .AW(AW)) u_fwd0 (
        .raddr_i     (rs),
        .rdata_i     (rdata0),
        .ex_we_i     (fwd_ex_we),
        .ex_waddr_i  (fwd_ex_waddr),
        .ex_wdata_i  (fwd_ex_wdata),
        .mem_we_i    (fwd_mem_we),
        .mem_waddr_i (fwd_mem_waddr),
        .mem_wdata_i (fwd_mem_wdata),
        .operand_c   (op0_c)
    );

    id_fwd_mux #(.DW(DW), .AW(AW)) u_fwd1 (
        .raddr_i     (rt),
        .rdata_i     (rdata1),
        .ex_we_i     (fwd_ex_we),
        .ex_waddr_i  (fwd_ex_waddr),
        .ex_wdata_i  (fwd_ex_wdata),
        .mem_we_i    (fwd_mem_we),
        .mem_waddr_i (fwd_mem_waddr),
        .mem_wdata_i (fwd_mem_wdata),
        .operand_c   (op1_c)
    );

    logic [DW-1:0] src0_c, src1_c;
    logic [AW-1:0] waddr_c;
    logic          we_c;

    always_comb begin
        src0_c = '0;
        src1_c = '0;
        case (dec.s0)
            S0_RS:   src0_c = op0_c;
            S0_RT:   src0_c = op1_c;
            default: src0_c = '0;
        endcase
        case (dec.s1)
            S1_ZIMM:  src1_c = {{(DW-16){1'b0}}, imm};
            S1_SIMM:  src1_c = {{(DW-16){imm[15]}}, imm};
            S1_LUI:   src1_c = {imm, {(DW-16){1'b0}}};
            S1_SHAMT: src1_c = DW'(shamt);
            S1_RT:    src1_c = op1_c;
            default:  src1_c = '0;
        endcase
    end

    assign waddr_c = dec.dest_rd ? rd : rt;
    assign we_c    = dec.wr & (waddr_c != '0);

    // Load in EX cannot forward yet; hold decode until it reaches MEM.
    assign stall_req = fwd_ex_is_load & fwd_ex_we & (fwd_ex_waddr != '0) &
                       ((re0 & (fwd_ex_waddr == rs)) | (re1 & (fwd_ex_waddr == rt)));

    logic               issue_c;
    logic               idex_valid_q, idex_we_q, idex_is_load_q, idex_illegal_q;
    logic [ALUOP_W-1:0] idex_aluop_q;
    logic [DW-1:0]      idex_src0_q, idex_src1_q, idex_pc_q;
    logic [AW-1:0]      idex_waddr_q;

    assign issue_c = ifid_valid_q & ~flush & ~stall_req;

    // ID/EX register: bubbles are all-zero.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_ || !issue_c) begin
            idex_valid_q   <= 1'b0;
            idex_aluop_q   <= '0;
            idex_src0_q    <= '0;
            idex_src1_q    <= '0;
            idex_we_q      <= 1'b0;
            idex_waddr_q   <= '0;
            idex_is_load_q <= 1'b0;
            idex_illegal_q <= 1'b0;
            idex_pc_q      <= '0;
        end else begin
            idex_valid_q   <= 1'b1;
            idex_aluop_q   <= dec.aluop;
            idex_src0_q    <= src0_c;
            idex_src1_q    <= src1_c;
            idex_we_q      <= we_c;
            idex_waddr_q   <= waddr_c;
            idex_is_load_q <= dec.is_load;
            idex_illegal_q <= dec.illegal;
            idex_pc_q      <= ifid_pc_q;
        end
    end

    assign idex_valid   = idex_valid_q;
    assign idex_aluop   = idex_aluop_q;
    assign idex_src0    = idex_src0_q;
    assign idex_src1    = idex_src1_q;
    assign idex_we      = idex_we_q;
    assign idex_waddr   = idex_waddr_q;
    assign idex_is_load = idex_is_load_q;
    assign idex_illegal = idex_illegal_q;
    assign idex_pc      = idex_pc_q;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: decode/forwarding vector table plus stall, flush and reset sequences.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst_;
    logic        if_valid;
    logic [31:0] if_pc, if_inst;
    logic        flush;
    logic        stall_req, re0, re1;
    logic [4:0]  raddr0, raddr1;
    logic [31:0] rdata0, rdata1;
    logic        fwd_ex_we, fwd_ex_is_load;
    logic [4:0]  fwd_ex_waddr;
    logic [31:0] fwd_ex_wdata;
    logic        fwd_mem_we;
    logic [4:0]  fwd_mem_waddr;
    logic [31:0] fwd_mem_wdata;
    logic        idex_valid, idex_we, idex_is_load, idex_illegal;
    logic [3:0]  idex_aluop;
    logic [31:0] idex_src0, idex_src1, idex_pc;
    logic [4:0]  idex_waddr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_stage dut (
        .clk(clk), .rst_(rst_), .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
        .flush(flush), .stall_req(stall_req), .re0(re0), .re1(re1),
        .raddr0(raddr0), .raddr1(raddr1), .rdata0(rdata0), .rdata1(rdata1),
        .fwd_ex_we(fwd_ex_we), .fwd_ex_is_load(fwd_ex_is_load),
        .fwd_ex_waddr(fwd_ex_waddr), .fwd_ex_wdata(fwd_ex_wdata),
        .fwd_mem_we(fwd_mem_we), .fwd_mem_waddr(fwd_mem_waddr), .fwd_mem_wdata(fwd_mem_wdata),
        .idex_valid(idex_valid), .idex_aluop(idex_aluop), .idex_src0(idex_src0),
        .idex_src1(idex_src1), .idex_we(idex_we), .idex_waddr(idex_waddr),
        .idex_is_load(idex_is_load), .idex_illegal(idex_illegal), .idex_pc(idex_pc)
    );

    typedef struct {
        logic [31:0] inst;
        logic [31:0] rd0, rd1;
        logic        ex_we;
        logic [4:0]  ex_wa;
        logic [31:0] ex_wd;
        logic        mem_we;
        logic [4:0]  mem_wa;
        logic [31:0] mem_wd;
        logic [3:0]  aluop;
        logic [31:0] s0, s1;
        logic        we;
        logic [4:0]  wa;
        logic        ld, ill, re0, re1;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic clear_fwd();
        fwd_ex_we = 1'b0; fwd_ex_is_load = 1'b0; fwd_ex_waddr = '0; fwd_ex_wdata = '0;
        fwd_mem_we = 1'b0; fwd_mem_waddr = '0; fwd_mem_wdata = '0;
    endtask

    task automatic apply_vec(input int i, input logic [31:0] pc);
        vec_t v;
        v = vecs[i];
        @(negedge clk);
        if_valid = 1'b1; if_inst = v.inst; if_pc = pc;
        @(negedge clk);
        if_valid = 1'b0;
        rdata0 = v.rd0; rdata1 = v.rd1;
        fwd_ex_we = v.ex_we; fwd_ex_waddr = v.ex_wa; fwd_ex_wdata = v.ex_wd;
        fwd_mem_we = v.mem_we; fwd_mem_waddr = v.mem_wa; fwd_mem_wdata = v.mem_wd;
        #1;
        chk($sformatf("v%0d stall", i), 32'(stall_req), 32'd0);
        chk($sformatf("v%0d re0", i), 32'(re0), 32'(v.re0));
        chk($sformatf("v%0d re1", i), 32'(re1), 32'(v.re1));
        chk($sformatf("v%0d raddr0", i), 32'(raddr0), 32'(v.inst[25:21]));
        chk($sformatf("v%0d raddr1", i), 32'(raddr1), 32'(v.inst[20:16]));
        @(negedge clk);
        chk($sformatf("v%0d valid", i), 32'(idex_valid), 32'd1);
        chk($sformatf("v%0d aluop", i), 32'(idex_aluop), 32'(v.aluop));
        chk($sformatf("v%0d src0", i), idex_src0, v.s0);
        chk($sformatf("v%0d src1", i), idex_src1, v.s1);
        chk($sformatf("v%0d we", i), 32'(idex_we), 32'(v.we));
        chk($sformatf("v%0d waddr", i), 32'(idex_waddr), 32'(v.wa));
        chk($sformatf("v%0d is_load", i), 32'(idex_is_load), 32'(v.ld));
        chk($sformatf("v%0d illegal", i), 32'(idex_illegal), 32'(v.ill));
        chk($sformatf("v%0d pc", i), idex_pc, pc);
    endtask

    initial begin
        //          inst          rd0       rd1       exwe exwa exwd      mwe mwa mwd      alu s0           s1           we wa ld il r0 r1
        vecs[0]  = '{32'h34011100, 32'h0,   32'h0,    0, 0, 32'h0,   0, 0, 32'h0,  1, 32'h0,   32'h1100,     1, 1, 0, 0, 1, 0};
        vecs[1]  = '{32'h00422021, 32'h99,  32'h99,   1, 2, 32'h55,  1, 2, 32'h11, 4, 32'h55,  32'h55,       1, 4, 0, 0, 1, 1};
        vecs[2]  = '{32'h00422021, 32'h99,  32'h99,   0, 2, 32'h55,  1, 2, 32'h11, 4, 32'h11,  32'h11,       1, 4, 0, 0, 1, 1};
        vecs[3]  = '{32'h00422021, 32'h99,  32'h99,   0, 2, 32'h55,  0, 2, 32'h11, 4, 32'h99,  32'h99,       1, 4, 0, 0, 1, 1};
        vecs[4]  = '{32'hFC000000, 32'h0,   32'h0,    0, 0, 32'h0,   0, 0, 32'h0,  0, 32'h0,   32'h0,        0, 0, 0, 1, 0, 0};
        vecs[5]  = '{32'h2425FFFF, 32'h10,  32'h0,    0, 0, 32'h0,   0, 0, 32'h0,  4, 32'h10,  32'hFFFFFFFF, 1, 5, 0, 0, 1, 0};
        vecs[6]  = '{32'h3C07ABCD, 32'h123, 32'h456,  0, 0, 32'h0,   0, 0, 32'h0,  1, 32'h0,   32'hABCD0000, 1, 7, 0, 0, 0, 0};
        vecs[7]  = '{32'h00094100, 32'h222, 32'h0F,   0, 0, 32'h0,   0, 0, 32'h0,  7, 32'h0F,  32'h4,        1, 8, 0, 0, 0, 1};
        vecs[8]  = '{32'h8C230008, 32'h100, 32'h0,    0, 0, 32'h0,   0, 0, 32'h0,  4, 32'h100, 32'h8,        1, 3, 1, 0, 1, 0};
        vecs[9]  = '{32'h00220023, 32'h5,   32'h3,    0, 0, 32'h0,   0, 0, 32'h0,  5, 32'h5,   32'h3,        0, 0, 0, 0, 1, 1};
        vecs[10] = '{32'h0022302A, 32'hAA,  32'hBB,   0, 0, 32'h0,   1, 1, 32'h77, 6, 32'h77,  32'hBB,       1, 6, 0, 0, 1, 1};
        vecs[11] = '{32'h306200F0, 32'h3,   32'h0,    1, 3, 32'h1FF, 0, 0, 32'h0,  2, 32'h1FF, 32'hF0,       1, 2, 0, 0, 1, 0};
        vecs[12] = '{32'h000050C2, 32'h0,   32'h77,   1, 0, 32'hFF,  1, 0, 32'hEE, 8, 32'h0,   32'h3,        1, 10, 0, 0, 0, 1};

        rst_ = 1'b0; if_valid = 1'b0; if_pc = '0; if_inst = '0; flush = 1'b0;
        rdata0 = '0; rdata1 = '0;
        clear_fwd();
        #12;
        chk("rst idex_valid", 32'(idex_valid), 32'd0);
        chk("rst idex_pc", idex_pc, 32'd0);
        chk("rst stall", 32'(stall_req), 32'd0);
        chk("rst re0", 32'(re0), 32'd0);
        @(negedge clk);
        rst_ = 1'b1;

        for (int i = 0; i < NV; i++) apply_vec(i, 32'h1000 + 32'(i * 4));

        // Asynchronous reset between edges while ID/EX holds a live micro-op.
        #2;
        rst_ = 1'b0;
        #1;
        chk("midrst valid", 32'(idex_valid), 32'd0);
        chk("midrst aluop", 32'(idex_aluop), 32'd0);
        chk("midrst src0", idex_src0, 32'd0);
        chk("midrst src1", idex_src1, 32'd0);
        chk("midrst waddr", 32'(idex_waddr), 32'd0);
        chk("midrst pc", idex_pc, 32'd0);
        chk("midrst stall", 32'(stall_req), 32'd0);
        @(negedge clk);
        rst_ = 1'b1;
        clear_fwd();

        // Load-use: LW $3 in EX, ADDU $4,$3,$5 in ID.
        @(negedge clk);
        if_valid = 1'b1; if_inst = 32'h00652021; if_pc = 32'h200;
        @(negedge clk);
        if_inst = 32'h34011100; if_pc = 32'h204;
        rdata0 = 32'h3333; rdata1 = 32'h5555;
        fwd_ex_we = 1'b1; fwd_ex_is_load = 1'b1; fwd_ex_waddr = 5'd3; fwd_ex_wdata = 32'hDEAD;
        #1;
        chk("lu stall", 32'(stall_req), 32'd1);
        @(negedge clk);
        chk("lu bubble", 32'(idex_valid), 32'd0);
        if_valid = 1'b0;
        clear_fwd();
        fwd_mem_we = 1'b1; fwd_mem_waddr = 5'd3; fwd_mem_wdata = 32'hBEEF;
        #1;
        chk("lu stall off", 32'(stall_req), 32'd0);
        chk("lu held re1", 32'(re1), 32'd1);
        chk("lu held raddr0", 32'(raddr0), 32'd3);
        @(negedge clk);
        chk("lu valid", 32'(idex_valid), 32'd1);
        chk("lu src0", idex_src0, 32'hBEEF);
        chk("lu src1", idex_src1, 32'h5555);
        chk("lu waddr", 32'(idex_waddr), 32'd4);
        chk("lu pc", idex_pc, 32'h200);
        clear_fwd();

        // Flush while a load-use stall is being requested.
        @(negedge clk);
        if_valid = 1'b1; if_inst = 32'h00652021; if_pc = 32'h300;
        @(negedge clk);
        if_valid = 1'b0;
        fwd_ex_we = 1'b1; fwd_ex_is_load = 1'b1; fwd_ex_waddr = 5'd3;
        flush = 1'b1;
        #1;
        chk("fl stall", 32'(stall_req), 32'd1);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("fl idex_valid", 32'(idex_valid), 32'd0);
        chk("fl stall off", 32'(stall_req), 32'd0);
        chk("fl re0", 32'(re0), 32'd0);
        @(negedge clk);
        chk("fl no issue", 32'(idex_valid), 32'd0);
        clear_fwd();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
